// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the Unicorn Explosion game controller.
// Holds the game state encoding, the speed code limits, the difficulty
// width and the switch priority encoders, so that every block consuming
// speed/difficulty codes decodes the switches identically.
package game_pkg;

  // Game phase encoding, also driven out on game_sequencer.state.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RUN       = 2'd2,
    DEAD      = 2'd3
  } game_state_e;

  localparam logic [2:0] SPEED_BASE = 3'd2;  // code when no speed switch is up
  localparam logic [2:0] SPEED_MAX  = 3'd6;  // code for the top speed switch
  localparam int         DIFF_W     = 2;

  // Highest raised switch wins: [3]->6, [2]->5, [1]->4, [0]->3, none->2.
  function automatic logic [2:0] encode_speed(input logic [3:0] sw);
    logic [2:0] code;
    if (sw[3]) begin
      code = SPEED_MAX;
    end else if (sw[2]) begin
      code = SPEED_MAX - 3'd1;
    end else if (sw[1]) begin
      code = SPEED_MAX - 3'd2;
    end else if (sw[0]) begin
      code = SPEED_MAX - 3'd3;
    end else begin
      code = SPEED_BASE;
    end
    return code;
  endfunction

  // Highest raised switch wins: [3]->3, [2]->2, [1]->1, otherwise 0.
  // Switch [0] alone deliberately maps to the easiest level.
  function automatic logic [DIFF_W-1:0] encode_difficulty(input logic [3:0] sw);
    logic [DIFF_W-1:0] code;
    if (sw[3]) begin
      code = 2'd3;
    end else if (sw[2]) begin
      code = 2'd2;
    end else if (sw[1]) begin
      code = 2'd1;
    end else begin
      code = 2'd0;
    end
    return code;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: turns the raw, asynchronous jump button into a clean
// one-cycle press pulse.
//   2-FF synchronizer -> optional debounce -> rising-edge detect.
// Build option: GAME_DEBOUNCE_EN
//   defined   : a level is accepted only after DEBOUNCE_CYCLES stable cycles
//               (press latency 2 + DEBOUNCE_CYCLES + 1 cycles).
//   undefined : synchronized level feeds the edge detector directly
//               (press latency 3 cycles, DEBOUNCE_CYCLES unused).
// Ports:
//   clk     in  1  system clock
//   rst     in  1  asynchronous active-high reset (button reads as released)
//   btn_raw in  1  raw button level, asynchronous to clk
//   press   out 1  registered one-cycle pulse per accepted press
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  logic [1:0] sync_r;
  logic       level_s;
  logic       level_prev_r;
  logic       press_r;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn_raw};
    end
  end

`ifdef GAME_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_r;
  logic            db_level_r;

  // Debounce: the accepted level follows the synchronized one only after
  // it has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_r   <= {DB_W{1'b0}};
      db_level_r <= 1'b0;
    end else if (sync_r[1] == db_level_r) begin
      db_cnt_r   <= {DB_W{1'b0}};
    end else if (db_cnt_r == DB_LAST) begin
      db_cnt_r   <= {DB_W{1'b0}};
      db_level_r <= sync_r[1];
    end else begin
      db_cnt_r   <= db_cnt_r + {{(DB_W-1){1'b0}}, 1'b1};
    end
  end

  assign level_s = db_level_r;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign level_s = sync_r[1];
`endif

  // Rising-edge detect on the accepted level; press is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_prev_r <= 1'b0;
      press_r      <= 1'b0;
    end else begin
      level_prev_r <= level_s;
      press_r      <= level_s & ~level_prev_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game controller for Unicorn Explosion.
// Sequences IDLE -> COUNTDOWN -> RUN -> DEAD -> IDLE, latches the speed and
// difficulty codes at game start and produces a speed-scaled one-cycle
// game-step enable from a phase accumulator on CLK100MHZ.
// Build option: GAME_DEBOUNCE_EN (see btn_conditioner) selects the full
// button debounce; without it the debounce counter is removed.
// Ports:
//   CLK100MHZ     in  1  only clock
//   reset_btn     in  1  asynchronous active-high reset
//   jump_btn      in  1  raw jump button
//   speed_in      in  4  speed switches (priority encoded)
//   difficulty_in in  4  difficulty switches (priority encoded)
//   isdead        in  1  collision flag from physics_engine
//   tick          out 1  one-cycle game step, RUN only
//   start         out 1  high while in RUN
//   jump          out 1  one-cycle pulse per accepted press, RUN only
//   speed         out 3  latched speed code 2..6
//   difficulty    out 2  latched difficulty code 0..3
//   state         out 2  IDLE=0 COUNTDOWN=1 RUN=2 DEAD=3
//   game_over     out 1  high while in DEAD
module game_sequencer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_ACC_W      = 27,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int HOLDOFF_TICKS   = 2
) (
  input  logic              CLK100MHZ,
  input  logic              reset_btn,
  input  logic              jump_btn,
  input  logic [3:0]        speed_in,
  input  logic [3:0]        difficulty_in,
  input  logic              isdead,
  output logic              tick,
  output logic              start,
  output logic              jump,
  output logic [2:0]        speed,
  output logic [DIFF_W-1:0] difficulty,
  output logic [1:0]        state,
  output logic              game_over
);

  localparam int CNT_MAX = (COUNTDOWN_TICKS > HOLDOFF_TICKS) ? COUNTDOWN_TICKS : HOLDOFF_TICKS;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD_CD = CNT_W'(COUNTDOWN_TICKS);
  localparam logic [CNT_W-1:0] CNT_LOAD_HO = CNT_W'(HOLDOFF_TICKS);

  game_state_e            state_r, state_next_s;
  logic [TICK_ACC_W-1:0]  acc_r, acc_next_s;
  logic [TICK_ACC_W:0]    acc_sum_s;
  logic                   itick_s;
  logic [CNT_W-1:0]       cnt_r, cnt_next_s;
  logic [2:0]             speed_r, speed_next_s;
  logic [DIFF_W-1:0]      diff_r, diff_next_s;
  logic                   start_r, game_over_r;
  logic                   tick_s, jump_s;
  logic                   press_s;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (CLK100MHZ),
    .rst    (reset_btn),
    .btn_raw(jump_btn),
    .press  (press_s)
  );

  // The internal tick is the carry out of the phase accumulator, so the
  // average period is exactly 2^TICK_ACC_W / speed with +-1 cycle jitter.
  assign acc_sum_s = {1'b0, acc_r} + (TICK_ACC_W+1)'(speed_r);
  assign itick_s   = acc_sum_s[TICK_ACC_W];

  // Next-state, counter, code latch and step/jump decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    speed_next_s = speed_r;
    diff_next_s  = diff_r;
    tick_s       = 1'b0;
    jump_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (press_s) begin
          state_next_s = COUNTDOWN;
          cnt_next_s   = CNT_LOAD_CD;
          speed_next_s = encode_speed(speed_in);
          diff_next_s  = encode_difficulty(difficulty_in);
        end else begin
          state_next_s = IDLE;
        end
      end
      COUNTDOWN: begin
        // Presses are ignored here, including one on the final tick.
        if (itick_s) begin
          if (cnt_r <= CNT_ONE) begin
            state_next_s = RUN;
            cnt_next_s   = CNT_ZERO;
          end else begin
            cnt_next_s   = cnt_r - CNT_ONE;
          end
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      RUN: begin
        // A collision outranks a coincident step or jump.
        if (isdead) begin
          state_next_s = DEAD;
          cnt_next_s   = CNT_LOAD_HO;
        end else begin
          tick_s = itick_s;
          jump_s = press_s;
        end
      end
      DEAD: begin
        if (cnt_r == CNT_ZERO) begin
          if (press_s) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DEAD;
          end
        end else if (itick_s) begin
          cnt_next_s = cnt_r - CNT_ONE;
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // Accumulator restarts on every state entry so each phase begins at phase 0.
  always_comb begin
    acc_next_s = acc_sum_s[TICK_ACC_W-1:0];
    if ((state_next_s != state_r) || (state_r == IDLE)) begin
      acc_next_s = {TICK_ACC_W{1'b0}};
    end else begin
      acc_next_s = acc_sum_s[TICK_ACC_W-1:0];
    end
  end

  // State, accumulator, counter, latched codes and registered state flags.
  always_ff @(posedge CLK100MHZ or posedge reset_btn) begin
    if (reset_btn) begin
      state_r     <= IDLE;
      acc_r       <= {TICK_ACC_W{1'b0}};
      cnt_r       <= CNT_ZERO;
      speed_r     <= SPEED_BASE;
      diff_r      <= {DIFF_W{1'b0}};
      start_r     <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      acc_r       <= acc_next_s;
      cnt_r       <= cnt_next_s;
      speed_r     <= speed_next_s;
      diff_r      <= diff_next_s;
      start_r     <= (state_next_s == RUN);
      game_over_r <= (state_next_s == DEAD);
    end
  end

  // tick and jump must land in the same cycle as the internal tick / press
  // and be suppressed by a coincident isdead, so they are decoded from
  // registered sources here rather than delayed another cycle.
  assign tick       = tick_s;
  assign jump       = jump_s;
  assign start      = start_r;
  assign game_over  = game_over_r;
  assign speed      = speed_r;
  assign difficulty = diff_r;
  assign state      = state_r;

endmodule
